// File: rtl/wb_register_file.sv
// Write-back stage and 32-entry architectural register file with commit tracking.
// Define WB_REGFILE_BYPASS_EN to forward the pending write-back value to the read ports.
module wb_register_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wwreg,
    input  logic                   wm2reg,
    input  logic [ADDR_WIDTH-1:0]  wdestReg,
    input  logic [DATA_WIDTH-1:0]  wr,
    input  logic [DATA_WIDTH-1:0]  wdo,
    input  logic [ADDR_WIDTH-1:0]  rs,
    input  logic [ADDR_WIDTH-1:0]  rt,
    output logic [DATA_WIDTH-1:0]  qa,
    output logic [DATA_WIDTH-1:0]  qb,
    output logic [DATA_WIDTH-1:0]  wbData,
    output logic [COUNT_WIDTH-1:0] commitCount,
    output logic [ADDR_WIDTH-1:0]  lastDest,
    output logic [DATA_WIDTH-1:0]  lastData
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0]  last_dest_q;
    logic [DATA_WIDTH-1:0]  last_data_q;
    logic                   commit;

    assign wbData = wm2reg ? wdo : wr;

    // Writes to $0 are dropped entirely so they neither store nor count.
    assign commit  = wwreg && (wdestReg != '0) && !reset;
    assign count_d = count_q + COUNT_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            count_q     <= '0;
            last_dest_q <= '0;
            last_data_q <= '0;
        end else if (commit) begin
            regs_q[wdestReg] <= wbData;
            count_q          <= count_d;
            last_dest_q      <= wdestReg;
            last_data_q      <= wbData;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    // commit already excludes reset and $0, so the forward path inherits both guards.
    assign qa = (rs == '0) ? '0 : ((commit && rs == wdestReg) ? wbData : regs_q[rs]);
    assign qb = (rt == '0) ? '0 : ((commit && rt == wdestReg) ? wbData : regs_q[rt]);
`else
    assign qa = (rs == '0) ? '0 : regs_q[rs];
    assign qb = (rt == '0) ? '0 : regs_q[rt];
`endif

    assign commitCount = count_q;
    assign lastDest    = last_dest_q;
    assign lastData    = last_data_q;

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Write-back end of the MEM/WB interface. Consumes the WB-stage control and data bundle (wwreg, wm2reg, wdestReg, wr, wdo) and selects the write-back value.
- Commits that value into the 32-entry architectural register file.
- Serves the two ID-stage read ports (rs/rt).
- Keeps a commit counter and a last-write record for debug and verification.

Parameters:
- DATA_WIDTH, 32, width of registers and data buses.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- COUNT_WIDTH, 32, width of the commit counter.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wwreg  input  1  WB-stage register-write enable.
- wm2reg  input  1  WB-stage select: 1 = memory data (wdo), 0 = ALU result (wr).
- wdestReg  input  ADDR_WIDTH  WB-stage destination register index.
- wr  input  DATA_WIDTH  WB-stage ALU result.
- wdo  input  DATA_WIDTH  WB-stage memory load data.
- rs  input  ADDR_WIDTH  read port A index.
- rt  input  ADDR_WIDTH  read port B index.
- qa  output  DATA_WIDTH  read port A data (combinational).
- qb  output  DATA_WIDTH  read port B data (combinational).
- wbData  output  DATA_WIDTH  selected write-back value (combinational).
- commitCount  output  COUNT_WIDTH  number of committed register writes (registered).
- lastDest  output  ADDR_WIDTH  index of most recent committed write (registered).
- lastData  output  DATA_WIDTH  value of most recent committed write (registered).

Behaviour:
- wbData = wm2reg ? wdo : wr. Purely combinational; valid regardless of wwreg.
- A commit occurs on posedge clock when reset=0, wwreg=1 and wdestReg != 0.
- On commit:
  - regs[wdestReg] <= wbData.
  - commitCount <= commitCount + 1.
  - lastDest <= wdestReg.
  - lastData <= wbData.
- No commit when wwreg=0 or wdestReg=0. All state holds, and the counter does not advance.
- Register 0 is hardwired to zero:
  - Never written.
  - A read of index 0 returns 0 on both ports, always, including under bypass.
- Read ports are combinational: qa = regs[rs], qb = regs[rt], subject to the bypass rules under Optional Feature.
- Both read ports may address the same register, or the write target, in the same cycle. Each port resolves independently.
- Commit latency: value visible through a non-bypassed read on the cycle after the commit edge.
- commitCount wraps modulo 2**COUNT_WIDTH. There is no saturation and no flag.
- Reset (synchronous, takes priority over a simultaneous commit): on posedge clock with reset=1:
  - All regs[1..31] <= 0.
  - commitCount <= 0, lastDest <= 0, lastData <= 0.
  - A write presented in the same cycle is discarded.
- Reset asserted mid-stream: the in-flight WB write is lost. The first commit after reset deasserts counts as 1.
- No X propagation: every register has a defined reset value, and the outputs are defined from the first post-reset cycle.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined (write-first bypass): if a commit is pending this cycle (wwreg=1, wdestReg!=0, reset=0) and rs==wdestReg, then qa = wbData. The same rule applies to qb with rt. This removes the WB->ID hazard without a split-phase clock.
- Not defined: qa/qb always return the stored register contents. A same-cycle read of the write target returns the old value; the new value appears the following cycle.
- Bypass is suppressed while reset=1, and for index 0.

Test Plan:
- Reset then reads -> assert reset 1 cycle, read rs=5, rt=31 -> qa=0, qb=0, commitCount=0, lastDest=0, lastData=0.
- ALU write -> wwreg=1, wm2reg=0, wdestReg=8, wr=0x0000_1234, wdo=0xDEAD_BEEF, one edge. Then rs=8 -> qa=0x0000_1234, commitCount=1, lastDest=8, lastData=0x0000_1234.
- Load write plus $0 guard -> first wm2reg=1, wdestReg=9, wdo=0xCAFE_F00D, then wwreg=1, wdestReg=0, wr=0xFFFF_FFFF:
  - rt=9 -> qb=0xCAFE_F00D.
  - rs=0 -> qa=0.
  - commitCount incremented once only.
- Same-cycle read of write target -> wdestReg=rs=rt=10, wr=0xA5A5_A5A5, old regs[10]=0x1:
  - With WB_REGFILE_BYPASS_EN: qa=qb=0xA5A5_A5A5 before the edge.
  - Without it: qa=qb=0x1 before the edge, 0xA5A5_A5A5 after.
- Reset collides with write -> reset=1, wwreg=1, wdestReg=12, wr=0x77 on the same edge -> regs[12]=0, commitCount=0. Next cycle, a commit to 12 gives commitCount=1.
- Counter wrap -> with COUNT_WIDTH=4, perform 17 commits to register 3 -> commitCount=1, lastDest=3.
